ic_irq_scheduler: RTL and testbench

- Interrupt sequencing controller between external request lines and the processor acknowledge/end-of-interrupt handshake.
- Captures rising edges into per-source pending bits and arbitrates among masked-in pending sources, using fixed or round-robin priority.
- Drives a single irq_out/irq_id pair and holds it through the ack and service phases.
- Recovers from a processor that never acknowledges by using an ack timeout.

---
 rtl/ic_irq_scheduler.sv | 119 +++++++++++
 tb/tb_ic_irq_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ic_irq_scheduler.sv
// Interrupt sequencer: edge capture into pending bits, fixed/round-robin arbitration,
// ack/eoi handshake with an ack timeout that withdraws an unanswered request.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no request driven; grant the next eligible source if any
// S_ASSERT  | irq_out high with irq_id stable, waiting for ack
// S_SERVICE | processor servicing irq_id; waiting for eoi
module ic_irq_scheduler #(
  parameter int NUM_SRC     = 8,
  parameter int ID_W        = 3,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] mask_reg,
  input  logic               rr_en,
  input  logic               ack,
  input  logic               eoi,
  output logic               irq_out,
  output logic [ID_W-1:0]    irq_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending,
  output logic               timeout_err
);

  localparam int TMR_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t state, state_d;

  logic [NUM_SRC-1:0] irq_in_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] elig_hi;
  logic [NUM_SRC-1:0] search;
  logic [NUM_SRC-1:0] clr;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    last_grant;
  logic [TMR_W-1:0]   timer;
  logic               tc;
  logic               ack_acc;
  logic               tmo;

  assign rise    = irq_in & ~irq_in_d;
  assign elig    = pending & mask_reg;
  assign tc      = (timer == '0);
  assign ack_acc = (state == S_ASSERT) && ack;
  assign tmo     = (state == S_ASSERT) && !ack && tc;
  assign clr     = ack_acc ? (NUM_SRC'(1) << irq_id) : '0;

  // Round-robin: prefer eligible sources above last_grant, otherwise wrap to the lowest.
  always_comb begin
    elig_hi  = '0;
    grant_id = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      elig_hi[i] = elig[i] && (i > int'(last_grant));
    end
    search = (rr_en && (|elig_hi)) ? elig_hi : elig;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (search[i]) grant_id = ID_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:    if (|elig) state_d = S_ASSERT;
      S_ASSERT: begin
        if (ack)                    state_d = S_SERVICE;
        else if (tc)                state_d = S_IDLE;
        else if (!mask_reg[irq_id]) state_d = S_IDLE;
      end
      S_SERVICE: if (eoi) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    irq_out    = (state == S_ASSERT);
    in_service = (state == S_SERVICE);
  end

  // Set beats clear when a fresh edge lands on the ack edge of the same source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_in_d    <= '0;
      pending     <= '0;
      irq_id      <= '0;
      last_grant  <= ID_W'(NUM_SRC - 1);
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      irq_in_d    <= irq_in;
      pending     <= (pending & ~clr) | rise;
      timeout_err <= tmo;
      if ((state == S_IDLE) && (|elig)) begin
        irq_id     <= grant_id;
        last_grant <= grant_id;
        timer      <= TMR_LOAD;
      end else if ((state == S_ASSERT) && !tc) begin
        timer <= timer - TMR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ic_irq_scheduler.sv
// Bench for ic_irq_scheduler: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_ic_irq_scheduler;

  localparam int N   = 8;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq_in = 8'h00;
  logic [7:0] mask_reg = 8'hFF;
  logic       rr_en = 1'b0;
  logic       ack = 1'b0;
  logic       eoi = 1'b0;
  logic       irq_out;
  logic [2:0] irq_id;
  logic       in_service;
  logic [7:0] pending;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ic_irq_scheduler #(.NUM_SRC(N), .ID_W(3), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask_reg(mask_reg), .rr_en(rr_en),
    .ack(ack), .eoi(eoi), .irq_out(irq_out), .irq_id(irq_id),
    .in_service(in_service), .pending(pending), .timeout_err(timeout_err)
  );

  // Model: phase 0 = waiting, 1 = requesting, 2 = being serviced.
  bit [7:0] m_pend = 8'h00;
  bit [7:0] m_prev = 8'h00;
  int       m_phase = 0;
  int       m_id = 0;
  int       m_last = N - 1;
  int       m_wait = 0;
  bit       m_terr = 1'b0;

  function automatic int pick(bit [7:0] e, bit rr, int last);
    int idx;
    if (rr) begin
      for (int k = 1; k <= N; k++) begin
        idx = (last + k) % N;
        if (e[idx]) return idx;
      end
    end else begin
      for (int i = 0; i < N; i++) if (e[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit [7:0] rise;
    bit [7:0] clr;
    bit       terr;
    int       w;
    rise   = irq_in & ~m_prev;
    m_prev = irq_in;
    clr    = 8'h00;
    terr   = 1'b0;
    case (m_phase)
      0: begin
        w = pick(m_pend & mask_reg, rr_en, m_last);
        if (w >= 0) begin
          m_id = w; m_last = w; m_wait = 0; m_phase = 1;
        end
      end
      1: begin
        if (ack) begin
          clr[m_id] = 1'b1; m_phase = 2;
        end else if (m_wait == TMO - 1) begin
          terr = 1'b1; m_phase = 0;
        end else if (!mask_reg[m_id]) begin
          m_phase = 0;
        end else begin
          m_wait++;
        end
      end
      default: if (eoi) m_phase = 0;
    endcase
    m_pend = (m_pend & ~clr) | rise;
    m_terr = terr;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pend = 8'h00; m_prev = 8'h00; m_phase = 0; m_id = 0;
        m_last = N - 1; m_wait = 0; m_terr = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("m_irq_out", irq_out, m_phase == 1);
    chk("m_in_service", in_service, m_phase == 2);
    chk("m_irq_id", irq_id, m_id);
    chk("m_pending", pending, m_pend);
    chk("m_timeout_err", timeout_err, m_terr);
  endtask

  task automatic tick();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    irq_in = 8'h00;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (!irq_out && n < 40) begin
      tick();
      n++;
    end
    chk("grant_wait", irq_out, 1);
  endtask

  task automatic serve(input int exp_id, input logic [7:0] exp_pend, input bit reraise);
    wait_grant();
    chk("grant_id", irq_id, exp_id);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("ack_irq_out", irq_out, 0);
    chk("ack_in_service", in_service, 1);
    chk("ack_pending", pending, exp_pend);
    if (reraise) begin
      irq_in[exp_id] = 1'b0; tick();
      irq_in[exp_id] = 1'b1; tick();
    end
    tick();
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("eoi_in_service", in_service, 0);
  endtask

  initial begin
    int cnt;
    tick(); tick();
    chk("rst_irq_out", irq_out, 0);
    chk("rst_pending", pending, 8'h00);
    chk("rst_irq_id", irq_id, 0);
    rst = 1'b0;

    // single source
    irq_in = 8'h20; tick();
    chk("single_pending", pending, 8'h20);
    chk("single_no_irq_yet", irq_out, 0);
    tick();
    chk("single_irq_out", irq_out, 1);
    chk("single_irq_id", irq_id, 5);
    tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    chk("single_ack_irq_out", irq_out, 0);
    chk("single_ack_in_service", in_service, 1);
    chk("single_ack_pending", pending, 8'h00);
    for (int i = 0; i < 5; i++) tick();
    chk("single_still_service", in_service, 1);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("single_eoi", in_service, 0);
    tick();
    chk("single_level_once", pending, 8'h00);
    chk("single_level_no_irq", irq_out, 0);
    irq_in = 8'h00; tick();

    // fixed priority
    irq_in = 8'h54; tick();
    chk("fixed_pending", pending, 8'h54);
    serve(2, 8'h50, 1'b0);
    serve(4, 8'h40, 1'b0);
    serve(6, 8'h00, 1'b0);
    irq_in = 8'h00; tick();

    // round-robin
    do_reset();
    rr_en = 1'b1;
    irq_in = 8'h0A; tick();
    chk("rr_pending", pending, 8'h0A);
    serve(1, 8'h08, 1'b1);
    serve(3, 8'h02, 1'b1);
    serve(1, 8'h08, 1'b1);
    serve(3, 8'h02, 1'b1);

    // masked source
    do_reset();
    rr_en = 1'b0;
    mask_reg = 8'hFE;
    irq_in = 8'h01; tick();
    chk("mask_pending", pending, 8'h01);
    chk("mask_no_irq", irq_out, 0);
    tick(); tick();
    chk("mask_still_no_irq", irq_out, 0);
    mask_reg = 8'hFF; tick();
    chk("unmask_irq_out", irq_out, 1);
    chk("unmask_irq_id", irq_id, 0);
    serve(0, 8'h00, 1'b0);
    irq_in = 8'h00; tick();

    // mask drop while asserting
    irq_in = 8'h04; tick(); tick();
    chk("wd_irq_out", irq_out, 1);
    chk("wd_irq_id", irq_id, 2);
    mask_reg = 8'hFB; tick();
    chk("wd_withdrawn", irq_out, 0);
    chk("wd_pending_kept", pending, 8'h04);
    tick();
    chk("wd_stays_idle", irq_out, 0);
    mask_reg = 8'hFF;
    serve(2, 8'h00, 1'b0);
    irq_in = 8'h00; tick();

    // ack timeout
    irq_in = 8'h10; tick(); tick();
    chk("tmo_irq_out", irq_out, 1);
    chk("tmo_irq_id", irq_id, 4);
    cnt = 0;
    while (irq_out && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("tmo_high_cycles", cnt, 16);
    chk("tmo_err_pulse", timeout_err, 1);
    chk("tmo_pending_kept", pending, 8'h10);
    tick();
    chk("tmo_err_single", timeout_err, 0);
    chk("tmo_regrant", irq_out, 1);
    chk("tmo_regrant_id", irq_id, 4);
    serve(4, 8'h00, 1'b0);
    irq_in = 8'h00; tick();

    // coincident set and clear
    irq_in = 8'h08;
    wait_grant();
    chk("coin_id", irq_id, 3);
    irq_in = 8'h00; tick();
    irq_in = 8'h08; ack = 1'b1; tick(); ack = 1'b0;
    chk("coin_pending", pending, 8'h08);
    chk("coin_service", in_service, 1);
    tick();
    eoi = 1'b1; tick(); eoi = 1'b0;
    serve(3, 8'h00, 1'b0);
    irq_in = 8'h00; tick();

    // reset in service
    irq_in = 8'h02;
    wait_grant();
    chk("mrst_id", irq_id, 1);
    ack = 1'b1; tick(); ack = 1'b0;
    irq_in = 8'h0E; tick();
    chk("mrst_pending_before", pending, 8'h0C);
    chk("mrst_service_before", in_service, 1);
    rst = 1'b1;
    #2;
    chk("mrst_irq_out", irq_out, 0);
    chk("mrst_in_service", in_service, 0);
    chk("mrst_irq_id", irq_id, 0);
    chk("mrst_pending", pending, 8'h00);
    irq_in = 8'h00;
    tick();
    rst = 1'b0;
    tick();

    // randomized traffic
    for (int it = 0; it < 3000; it++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
      end
      if (it % 128 == 0) mask_reg = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      if (it % 256 == 0) rr_en = 1'($urandom_range(0, 1));
      ack = ($urandom_range(0, 9) == 0);
      eoi = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0; ack = 1'b0; eoi = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
